// File: rtl/pio_ram_emu_responder_pkg.sv
// Shared constants, header codes and types for the PIO RAM emulator responder.
// Header codes must match the pio_ram_emu_transmitter/receiver side.
package pio_ram_emu_responder_pkg;

  localparam logic [3:0] SEND_READ_ADDR  = 4'h1;
  localparam logic [3:0] SEND_WRITE_ADDR = 4'h2;
  localparam logic [3:0] SEND_WRITE_DATA = 4'h3;

  localparam int unsigned PIO_RAM_EMU_MSG_PAIRS   = 10;
  localparam int unsigned PIO_RAM_EMU_REPLY_PAIRS = 8;

  localparam logic [1:0] PIO_RAM_EMU_PINS_IDLE  = 2'b11;
  localparam logic [1:0] PIO_RAM_EMU_PINS_START = 2'b00;

  localparam int unsigned HDR_W   = 4;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned MSG_W   = HDR_W + WORD_W;
  localparam int unsigned STAMP_W = 16;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_DISPATCH
  } rx_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef struct packed {
    logic [HDR_W-1:0]  header;
    logic [WORD_W-1:0] data;
  } msg_t;

  typedef struct packed {
    logic [WORD_W-1:0]  data;
    logic [STAMP_W-1:0] due;
  } reply_t;

  // Wrap-safe "now has reached due" on a free-running timestamp.
  function automatic logic stamp_reached(input logic [STAMP_W-1:0] now,
                                         input logic [STAMP_W-1:0] due);
    logic [STAMP_W-1:0] diff;
    diff = now - due;
    return ~diff[STAMP_W-1];
  endfunction

endpackage

// File: rtl/pio_ram_emu_frame_tx.sv
// Reply serializer: start cycle (00) followed by 8 MSB-first bit pairs.
// Accepts the next word while the last pair is on the line, so frames can abut.
module pio_ram_emu_frame_tx
  import pio_ram_emu_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] word,
  input  logic              valid,
  output logic              ready_c,
  output logic              active_c,
  output logic [1:0]        tx_pins
);

  localparam logic [3:0] LAST_PAIR = 4'(PIO_RAM_EMU_REPLY_PAIRS);

  tx_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [1:0]        pins_d;

  assign active_c = (state_q == TX_SEND);
  assign ready_c  = (state_q == TX_IDLE) || (cnt_q == LAST_PAIR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      tx_pins <= PIO_RAM_EMU_PINS_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tx_pins <= pins_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pins_d  = tx_pins;
    case (state_q)
      TX_IDLE: begin
        pins_d = PIO_RAM_EMU_PINS_IDLE;
        if (valid) begin
          state_d = TX_SEND;
          pins_d  = PIO_RAM_EMU_PINS_START;
          sh_d    = word;
          cnt_d   = '0;
        end
      end
      TX_SEND: begin
        if (cnt_q == LAST_PAIR) begin
          if (valid) begin
            pins_d = PIO_RAM_EMU_PINS_START;
            sh_d   = word;
            cnt_d  = '0;
          end else begin
            state_d = TX_IDLE;
            pins_d  = PIO_RAM_EMU_PINS_IDLE;
          end
        end else begin
          pins_d = sh_q[WORD_W-1 -: 2];
          sh_d   = {sh_q[WORD_W-3:0], 2'b00};
          cnt_d  = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        pins_d  = PIO_RAM_EMU_PINS_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/pio_ram_emu_responder.sv
// Far end of the PIO RAM emulator link: decodes 2-bit frames, executes them on a
// word memory and serializes read replies. Optional PIO_RAM_EMU_RESPONDER_STATS_EN adds counters.
module pio_ram_emu_responder
  import pio_ram_emu_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS        = 8,
  parameter int unsigned READ_LATENCY     = 4,
  parameter int unsigned REPLY_FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  rx_pins,
  output logic [1:0]  tx_pins,
  output logic        overflow,
  output logic        busy
`ifdef PIO_RAM_EMU_RESPONDER_STATS_EN
  ,
  output logic [15:0] read_count,
  output logic [15:0] write_count
`endif
);

  localparam int unsigned MEM_WORDS = 2 ** ADDR_BITS;
  localparam int unsigned PTR_W     = (REPLY_FIFO_DEPTH > 1) ? $clog2(REPLY_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(REPLY_FIFO_DEPTH + 1);
  localparam logic [3:0]  LAST_MSG  = 4'(PIO_RAM_EMU_MSG_PAIRS - 1);

  // ---------------- Rx deserializer ----------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [3:0]       pair_cnt_q, pair_cnt_d;
  logic [MSG_W-1:0] msg_sh_q, msg_sh_d;
  msg_t             msg;

  assign msg = msg_t'(msg_sh_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      pair_cnt_q <= '0;
      msg_sh_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      pair_cnt_q <= pair_cnt_d;
      msg_sh_q   <= msg_sh_d;
    end
  end

  // Dispatch cycle doubles as an idle cycle so back-to-back frames are accepted.
  always_comb begin
    rx_state_d = rx_state_q;
    pair_cnt_d = pair_cnt_q;
    msg_sh_d   = msg_sh_q;
    case (rx_state_q)
      RX_IDLE, RX_DISPATCH: begin
        rx_state_d = RX_IDLE;
        if (rx_pins == PIO_RAM_EMU_PINS_START) begin
          rx_state_d = RX_SHIFT;
          pair_cnt_d = '0;
        end
      end
      RX_SHIFT: begin
        msg_sh_d   = {msg_sh_q[MSG_W-3:0], rx_pins};
        pair_cnt_d = pair_cnt_q + 4'd1;
        if (pair_cnt_q == LAST_MSG) rx_state_d = RX_DISPATCH;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Dispatch and memory ----------------
  logic                 dispatch, rd_req, wa_req, wd_req;
  logic [ADDR_BITS-1:0] msg_addr, waddr_q;
  logic [WORD_W-1:0]    mem [MEM_WORDS];
  logic [WORD_W-1:0]    rd_word;

  assign dispatch = (rx_state_q == RX_DISPATCH);
  assign rd_req   = dispatch && (msg.header == SEND_READ_ADDR);
  assign wa_req   = dispatch && (msg.header == SEND_WRITE_ADDR);
  assign wd_req   = dispatch && (msg.header == SEND_WRITE_DATA);
  assign msg_addr = msg.data[ADDR_BITS-1:0];
  assign rd_word  = mem[msg_addr];

  always_ff @(posedge clk) begin
    if (wd_req) mem[waddr_q] <= msg.data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waddr_q <= '0;
    end else if (wa_req) begin
      waddr_q <= msg_addr;
    end else if (wd_req) begin
      waddr_q <= waddr_q + ADDR_BITS'(1);
    end
  end

  // ---------------- Reply FIFO with due timestamps ----------------
  logic [STAMP_W-1:0] now_q;
  reply_t             fifo_q [REPLY_FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               fifo_empty, fifo_full;
  reply_t             incoming, cand;
  logic               cand_valid, tx_valid, tx_ready_c, tx_active_c, tx_accept;
  logic               pop, bypass, push, drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(REPLY_FIFO_DEPTH));
  assign incoming   = '{data: rd_word, due: now_q + STAMP_W'(READ_LATENCY - 1)};
  assign cand       = fifo_empty ? incoming : fifo_q[rd_ptr_q];
  assign cand_valid = !fifo_empty || rd_req;
  assign tx_valid   = cand_valid && stamp_reached(now_q, cand.due);
  assign tx_accept  = tx_valid && tx_ready_c;
  // An incoming read due immediately skips the FIFO (READ_LATENCY of 1).
  assign pop        = tx_accept && !fifo_empty;
  assign bypass     = tx_accept && fifo_empty;
  assign push       = rd_req && !bypass && (!fifo_full || pop);
  assign drop       = rd_req && !bypass && fifo_full && !pop;
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= incoming;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      now_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      now_q   <= now_q + STAMP_W'(1);
      count_q <= count_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(REPLY_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(REPLY_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (drop) overflow <= 1'b1;
      // Registered from next-state terms so it tracks the current state exactly.
      busy <= (rx_state_d != RX_IDLE) || (count_d != '0) || tx_accept ||
              (tx_active_c && !tx_ready_c);
    end
  end

  pio_ram_emu_frame_tx u_frame_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .word     (cand.data),
    .valid    (tx_valid),
    .ready_c  (tx_ready_c),
    .active_c (tx_active_c),
    .tx_pins  (tx_pins)
  );

`ifdef PIO_RAM_EMU_RESPONDER_STATS_EN
  // Traffic counters; dropped reads still count as reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (rd_req) read_count  <= read_count + 16'd1;
      if (wd_req) write_count <= write_count + 16'd1;
    end
  end
`endif

endmodule
